// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW-hazard stall, taken-branch flush and STOP drain/halt
// sequencing for the 4-stage 8-bit pipeline, plus stall/flush perf counters.
module pipe_hazard_ctrl #(
   parameter int          CNT_W = 16,
   parameter logic [7:0]  NOP   = 8'b0000_1010
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [7:0]       ir_i,
   input  logic [7:0]       ir3_i,
   input  logic [7:0]       ir4_i,
   input  logic             n_i,
   input  logic             z_i,
   input  logic             resume_i,
   output logic             pc_write_o,
   output logic             ir_load_o,
   output logic             flush_ir_o,
   output logic             bubble3_o,
   output logic             inc_count_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] stall_count_o,
   output logic [CNT_W-1:0] flush_count_o
);
   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

   state_e           state_q;
   logic [1:0]       drain_q;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             run, taken, haz, stop;

   // {valid, reg} of the register an instruction writes
   function automatic logic [2:0] dst(input logic [7:0] i);
      logic [3:0] op;
      op = i[3:0];
      dst[2] = i != NOP && (op == 4'd0 || op == 4'd4 || op == 4'd6 || op == 4'd8 ||
               op[2:0] == 3'b011 || op[2:0] == 3'b111);
      dst[1:0] = op[2:0] == 3'b111 ? 2'd1 : i[7:6];
   endfunction

   function automatic logic reads(input logic [7:0] i, input logic [2:0] d);
      logic [3:0] op;
      logic       rd_r1, rd_r2;
      op = i[3:0];
      rd_r1 = op == 4'd2 || op == 4'd4 || op == 4'd6 || op == 4'd8 || op[2:0] == 3'b011;
      rd_r2 = op == 4'd0 || op == 4'd2 || op == 4'd4 || op == 4'd6 || op == 4'd8;
      reads = d[2] && i != NOP && ((rd_r1 && i[7:6] == d[1:0]) || (rd_r2 && i[5:4] == d[1:0]) ||
              (op[2:0] == 3'b111 && d[1:0] == 2'd1));
   endfunction

   always_comb begin
      run = state_q == RUN;
      taken = run && ((ir3_i[3:0] == 4'd5 && z_i) || (ir3_i[3:0] == 4'd9 && !z_i) ||
              (ir3_i[3:0] == 4'd13 && !n_i));
      haz = run && (reads(ir_i, dst(ir3_i)) || reads(ir_i, dst(ir4_i)));
      stop = run && ir_i[3:0] == 4'd1;
      pc_write_o = run && (taken || !(haz || stop));
      ir_load_o = run && !(taken || haz || stop);
      flush_ir_o = taken || (state_q == HALT && resume_i);
      bubble3_o = !run || taken || haz || stop;
      inc_count_o = state_q != HALT;
      halted_o = state_q == HALT;
   end

   assign stall_count_o = stall_q;
   assign flush_count_o = flush_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         drain_q <= 2'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (taken && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
               if (!taken && haz && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
               if (!taken && !haz && stop) begin
                  state_q <= DRAIN;
                  drain_q <= 2'd2;
               end
            end
            DRAIN: begin
               drain_q <= drain_q - 2'd1;
               if (drain_q == 2'd1) state_q <= HALT;
            end
            HALT: if (resume_i) state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench; a register-set reference model predicts
// each cycle's controls and counters, a negedge monitor compares them.
module tb_pipe_hazard_ctrl;
   localparam logic [7:0] NOP = 8'b0000_1010;
   localparam logic [7:0] ADD1 = 8'b01_00_0100;
   localparam logic [7:0] LDR1 = 8'b00_01_0000;
   localparam logic [7:0] STOP = 8'b0000_0001;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  ir = NOP, ir3 = NOP, ir4 = NOP;
   logic        n = 1'b0, z = 1'b0, resume = 1'b0;
   logic        pcw, irl, fl, b3, inc, hlt;
   logic [15:0] stc, flc;

   typedef struct packed {
      logic [5:0]  ctl;
      logic [15:0] st;
      logic [15:0] fl;
   } exp_t;
   exp_t q[$];

   int total = 0, bad = 0;
   int mode = 0, left = 0, stall_m = 0, flush_m = 0;

   pipe_hazard_ctrl #(.CNT_W(16), .NOP(NOP)) dut (
      .clk_i(clk), .rst_ni(rst_n), .ir_i(ir), .ir3_i(ir3), .ir4_i(ir4), .n_i(n), .z_i(z),
      .resume_i(resume), .pc_write_o(pcw), .ir_load_o(irl), .flush_ir_o(fl), .bubble3_o(b3),
      .inc_count_o(inc), .halted_o(hlt), .stall_count_o(stc), .flush_count_o(flc)
   );

   always #5 clk = ~clk;

   // register sets as 4-bit masks
   function automatic logic [3:0] rd_set(input logic [7:0] i);
      logic [3:0] op = i[3:0];
      if (op == 4'd0) return 4'b1 << i[5:4];
      if (op == 4'd2 || op == 4'd4 || op == 4'd6 || op == 4'd8) return (4'b1 << i[7:6]) | (4'b1 << i[5:4]);
      if (op[2:0] == 3'b111) return 4'b0010;
      if (op[2:0] == 3'b011) return 4'b1 << i[7:6];
      return 4'b0;
   endfunction

   function automatic logic [3:0] wr_set(input logic [7:0] i);
      logic [3:0] op = i[3:0];
      if (op == 4'd0 || op == 4'd4 || op == 4'd6 || op == 4'd8 || op[2:0] == 3'b011) return 4'b1 << i[7:6];
      if (op[2:0] == 3'b111) return 4'b0010;
      return 4'b0;
   endfunction

   function automatic bit m_taken();
      return (ir3[3:0] == 4'd5 && z) || (ir3[3:0] == 4'd9 && !z) || (ir3[3:0] == 4'd13 && !n);
   endfunction

   function automatic bit m_haz();
      return (rd_set(ir) & (wr_set(ir3) | wr_set(ir4))) != 4'b0;
   endfunction

   // {PCwrite, IRload, FlushIR, Bubble3, IncCount, Halted}
   function automatic logic [5:0] m_ctl();
      if (mode == 2) return {2'b00, resume, 3'b101};
      if (mode == 1) return 6'b000110;
      if (m_taken()) return 6'b101110;
      if (m_haz() || ir[3:0] == 4'd1) return 6'b000110;
      return 6'b110010;
   endfunction

   task automatic m_step();
      if (mode == 0) begin
         if (m_taken()) flush_m = flush_m < 65535 ? flush_m + 1 : 65535;
         else if (m_haz()) stall_m = stall_m < 65535 ? stall_m + 1 : 65535;
         else if (ir[3:0] == 4'd1) begin mode = 1; left = 2; end
      end else if (mode == 1) begin
         left = left - 1;
         if (left == 0) mode = 2;
      end else if (resume) mode = 0;
   endtask

   task automatic cyc(input logic [7:0] a, b, c, input logic nn, zz, rs, input bit chk);
      ir = a; ir3 = b; ir4 = c; n = nn; z = zz; resume = rs;
      if (chk) q.push_back('{m_ctl(), 16'(stall_m), 16'(flush_m)});
      m_step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ir = NOP; ir3 = NOP; ir4 = NOP; n = 0; z = 0; resume = 0;
      mode = 0; left = 0; stall_m = 0; flush_m = 0;
      q.push_back('{m_ctl(), 16'd0, 16'd0});
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         total += 3;
         if ({pcw, irl, fl, b3, inc, hlt} !== e.ctl) begin
            bad++;
            $display("FAIL ctl t=%0t got=%b want=%b", $time, {pcw, irl, fl, b3, inc, hlt}, e.ctl);
         end
         if (stc !== e.st) begin
            bad++;
            $display("FAIL stall_count t=%0t got=%0d want=%0d", $time, stc, e.st);
         end
         if (flc !== e.fl) begin
            bad++;
            $display("FAIL flush_count t=%0t got=%0d want=%0d", $time, flc, e.fl);
         end
      end
   end

   initial begin
      int guard;
      @(posedge clk); #1;
      do_reset();
      cyc(LDR1, ADD1, NOP, 0, 0, 0, 1);
      cyc(LDR1, NOP, ADD1, 0, 0, 0, 1);
      cyc(LDR1, 8'b11_00_0100, NOP, 0, 0, 0, 1);
      cyc(NOP, 8'h05, NOP, 0, 1, 0, 1);
      cyc(NOP, 8'h05, NOP, 0, 0, 0, 1);
      cyc(NOP, 8'h09, NOP, 0, 0, 0, 1);
      cyc(NOP, 8'h0D, NOP, 0, 1, 0, 1);
      cyc(NOP, NOP, NOP, 0, 0, 1, 1);
      cyc(STOP, NOP, NOP, 0, 0, 0, 1);
      repeat (4) cyc(STOP, NOP, NOP, 0, 0, 0, 1);
      cyc(STOP, NOP, NOP, 0, 0, 1, 1);
      cyc(NOP, NOP, NOP, 0, 0, 0, 1);
      cyc(STOP, 8'h09, NOP, 0, 0, 0, 1);
      cyc(NOP, NOP, NOP, 0, 0, 0, 1);
      cyc(STOP, NOP, NOP, 0, 0, 0, 1);
      cyc(STOP, NOP, NOP, 0, 0, 1, 1);
      do_reset();
      cyc(NOP, NOP, NOP, 0, 0, 0, 1);
      for (int i = 0; i < 400; i++)
         cyc(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 2) == 0, 1);
      do_reset();
      for (int i = 0; i < 65534; i++) cyc(LDR1, ADD1, NOP, 1, 1, 0, 0);
      repeat (3) cyc(LDR1, ADD1, NOP, 1, 1, 0, 1);
      cyc(NOP, NOP, NOP, 0, 0, 0, 1);
      guard = 0;
      while (q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
      if (q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain_queue left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
